// File: rtl/pwm_capture.sv
// PWM input capture: measures period (rise-to-rise) and high time (rise-to-fall) of i_pwm_in
// in prescaled clock ticks. Wishbone-mapped control/status, publishes high time on o_DC.
//
// state | meaning
// IDLE  | disabled, ctrl[0]=0
// ARM   | enabled, waiting for the first rising edge
// HIGH  | counting high phase, waiting for falling edge
// LOW   | counting low phase, waiting for the closing rising edge
module pwm_capture (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [15:0] i_wb_data,
    output logic [15:0] o_wb_data,
    output logic        o_wb_ack,
    input  logic        i_pwm_in,
    output logic [15:0] o_DC,
    output logic        o_valid_DC,
    output logic        o_irq
);

    localparam logic [15:0] ADR_CTRL    = 16'd0;
    localparam logic [15:0] ADR_DIVISOR = 16'd2;
    localparam logic [15:0] ADR_PERIOD  = 16'd4;
    localparam logic [15:0] ADR_HIGH    = 16'd6;
    localparam logic [15:0] ADR_STATUS  = 16'd8;
    localparam logic [15:0] CT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q,  ctrl_d;
    logic [15:0] div_q,   div_d;
    logic        done_q,  done_d;
    logic        ovf_q,   ovf_d;
    logic [15:0] period_q;
    logic [15:0] high_q;
    logic [15:0] high_tmp_q;
    logic [15:0] ct_q;
    logic [15:0] presc_q;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic        valid_q;

    logic        wr;
    logic        ctrl_wr;
    logic        div_wr;
    logic        stat_wr;
    logic        soft_rst;
    logic        disable_wr;
    logic        sample;
    logic        rise;
    logic        fall;
    logic        tick;
    logic [15:0] ct_inc;
    logic        busy;

    assign wr         = i_wb_cyc & i_wb_stb & i_wb_we;
    assign ctrl_wr    = wr & (i_wb_adr == ADR_CTRL);
    assign div_wr     = wr & (i_wb_adr == ADR_DIVISOR);
    assign stat_wr    = wr & (i_wb_adr == ADR_STATUS);
    assign soft_rst   = ctrl_wr & i_wb_data[7];
    assign disable_wr = ctrl_wr & ~i_wb_data[0];

    assign sample = sync_q[1] ^ ctrl_q[3];
    assign rise   = sample & ~prev_q;
    assign fall   = ~sample & prev_q;

    // Compare with >= so a divisor lowered mid-count still yields a tick promptly.
    assign tick   = (div_q <= 16'd1) | (presc_q >= (div_q - 16'd1));
    assign ct_inc = (ct_q == CT_MAX) ? ct_q : ct_q + {15'd0, tick};
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        if (ctrl_wr) ctrl_d = i_wb_data[3:0];
        if (div_wr)  div_d  = i_wb_data;
        if (stat_wr) begin
            done_d = done_q & ~i_wb_data[0];
            ovf_d  = ovf_q  & ~i_wb_data[1];
        end
    end

    // Hardware events are assigned after the bus defaults so they win over W1C.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            div_q      <= 16'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            period_q   <= 16'd0;
            high_q     <= 16'd0;
            high_tmp_q <= 16'd0;
            ct_q       <= 16'd0;
            presc_q    <= 16'd0;
            sync_q     <= 2'd0;
            prev_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_pwm_in};
            prev_q  <= sample;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            valid_q <= 1'b0;
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;

            if (soft_rst) begin
                state_q    <= S_IDLE;
                sync_q     <= 2'd0;
                prev_q     <= 1'b0;
                presc_q    <= 16'd0;
                ct_q       <= 16'd0;
                high_tmp_q <= 16'd0;
                done_q     <= 1'b0;
                ovf_q      <= 1'b0;
            end else if (disable_wr) begin
                state_q <= S_IDLE;
                ct_q    <= 16'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ct_q <= 16'd0;
                        if (ctrl_q[0]) state_q <= S_ARM;
                    end
                    S_ARM: begin
                        if (rise) begin
                            ct_q    <= 16'd0;
                            presc_q <= 16'd0;
                            state_q <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            high_tmp_q <= ct_inc;
                            ct_q       <= ct_inc;
                            presc_q    <= 16'd0;
                            state_q    <= S_LOW;
                        end else if (ct_inc == CT_MAX) begin
                            ovf_q <= 1'b1;
                            ct_q  <= 16'd0;
                            if (ctrl_q[1]) begin
                                state_q <= S_ARM;
                            end else begin
                                state_q   <= S_IDLE;
                                ctrl_q[0] <= 1'b0;
                            end
                        end else begin
                            ct_q <= ct_inc;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            period_q <= ct_inc;
                            high_q   <= high_tmp_q;
                            valid_q  <= 1'b1;
                            done_q   <= 1'b1;
                            ct_q     <= 16'd0;
                            presc_q  <= 16'd0;
                            if (ctrl_q[1]) begin
                                state_q <= S_HIGH;
                            end else begin
                                state_q   <= S_IDLE;
                                ctrl_q[0] <= 1'b0;
                            end
                        end else if (ct_inc == CT_MAX) begin
                            ovf_q <= 1'b1;
                            ct_q  <= 16'd0;
                            if (ctrl_q[1]) begin
                                state_q <= S_ARM;
                            end else begin
                                state_q   <= S_IDLE;
                                ctrl_q[0] <= 1'b0;
                            end
                        end else begin
                            ct_q <= ct_inc;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_wb_data = 16'd0;
        case (i_wb_adr)
            ADR_CTRL:    o_wb_data = {12'd0, ctrl_q};
            ADR_DIVISOR: o_wb_data = div_q;
            ADR_PERIOD:  o_wb_data = period_q;
            ADR_HIGH:    o_wb_data = high_q;
            ADR_STATUS:  o_wb_data = {13'd0, busy, ovf_q, done_q};
            default:     o_wb_data = 16'd0;
        endcase
    end

    assign o_wb_ack   = i_wb_stb;
    assign o_DC       = high_q;
    assign o_valid_DC = valid_q;
    assign o_irq      = ctrl_q[2] & (done_q | ovf_q);

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: random and directed PWM waveforms, expected measurements queued
// at stimulus time and checked by an independent monitor on o_valid_DC.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [15:0] adr, wdat;
    logic [15:0] rdat;
    logic        ack;
    logic        pwm;
    logic [15:0] dc;
    logic        valid_dc;
    logic        irq;

    always #5 clk = ~clk;

    pwm_capture dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_adr  (adr),
        .i_wb_data (wdat),
        .o_wb_data (rdat),
        .o_wb_ack  (ack),
        .i_pwm_in  (pwm),
        .o_DC      (dc),
        .o_valid_DC(valid_dc),
        .o_irq     (irq)
    );

    typedef struct {
        logic [15:0] high;
        logic [15:0] period;
    } meas_t;

    meas_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] last_high   = 16'd0;
    logic [15:0] last_period = 16'd0;
    int          h_arr[8];
    int          l_arr[8];

    // Reference: prescaler restarts on each edge, so each phase contributes floor(len/div) ticks.
    function automatic int ticks(input int n, input int div);
        return (div <= 1) ? n : n / div;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        #1;
        check16(name, rdat, exp);
        check16("ack", {15'd0, ack}, 16'd1);
        #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives n full cycles in "seen" polarity starting with a rise; ends seen-high.
    task automatic run_wave(input bit inv, input int div, input int n, input bit single);
        int hi, pr;
        @(negedge clk);
        pwm = 1'b1 ^ inv;
        for (int i = 0; i < n; i++) begin
            wait_cycles(h_arr[i]);
            pwm = 1'b0 ^ inv;
            wait_cycles(l_arr[i]);
            pwm = 1'b1 ^ inv;
            if (!single || i == 0) begin
                hi = ticks(h_arr[i], div);
                pr = hi + ticks(l_arr[i], div);
                exp_q.push_back('{high: 16'(hi), period: 16'(pr)});
                last_high   = 16'(hi);
                last_period = 16'(pr);
            end
        end
    endtask

    task automatic stop_all();
        wb_write(16'd0, 16'h0080);
        pwm = 1'b0;
        wait_cycles(6);
    endtask

    initial begin : monitor
        meas_t m;
        forever begin
            @(negedge clk);
            if (valid_dc === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: o_DC=%h with no expected measurement", dc);
                end else begin
                    m = exp_q.pop_front();
                    check16("o_DC", dc, m.high);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int div;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 16'd0; wdat = 16'd0; pwm = 1'b0;
        wait_cycles(3);
        rst = 1'b0;

        // reset state, and no activity while disabled
        check16("irq_reset", {15'd0, irq}, 16'd0);
        check16("dc_reset", dc, 16'd0);
        for (int a = 0; a <= 8; a += 2) rd_check("reg_reset", 16'(a), 16'd0);
        rd_check("unmapped", 16'd10, 16'd0);
        for (int i = 0; i < 20; i++) begin
            pwm = ~pwm;
            wait_cycles(7);
        end
        pwm = 1'b0;
        wait_cycles(6);
        rd_check("status_idle", 16'd8, 16'd0);

        // continuous, divisor 1, 100/30
        wb_write(16'd2, 16'd1);
        rd_check("divisor", 16'd2, 16'd1);
        wb_write(16'd0, 16'h0003);
        wait_cycles(4);
        for (int i = 0; i < 4; i++) begin h_arr[i] = 30; l_arr[i] = 70; end
        run_wave(1'b0, 1, 4, 1'b0);
        wait_cycles(6);
        rd_check("t2_period", 16'd4, 16'd100);
        rd_check("t2_high", 16'd6, 16'd30);
        check16("t2_dc", dc, 16'd30);
        rd_check("t2_status", 16'd8, 16'h0005);
        check16("t2_irq", {15'd0, irq}, 16'd0);
        wb_write(16'd0, 16'h0000);
        pwm = 1'b0;
        wait_cycles(4);
        rd_check("t2_status_off", 16'd8, 16'h0001);
        stop_all();
        rd_check("softrst_status", 16'd8, 16'd0);

        // single-shot with divisor 4 and irq
        wb_write(16'd2, 16'd4);
        wb_write(16'd0, 16'h0005);
        wait_cycles(4);
        for (int i = 0; i < 2; i++) begin h_arr[i] = 100; l_arr[i] = 300; end
        run_wave(1'b0, 4, 2, 1'b1);
        wait_cycles(6);
        check16("t3_irq", {15'd0, irq}, 16'd1);
        rd_check("t3_ctrl", 16'd0, 16'h0004);
        rd_check("t3_period", 16'd4, 16'd100);
        rd_check("t3_high", 16'd6, 16'd25);
        rd_check("t3_status", 16'd8, 16'h0001);
        wb_write(16'd8, 16'h0001);
        wait_cycles(1);
        check16("t3_irq_clr", {15'd0, irq}, 16'd0);
        rd_check("t3_status_clr", 16'd8, 16'd0);
        stop_all();

        // inverted input, 400/100 raw -> 300 high seen
        pwm = 1'b1;
        wait_cycles(5);
        wb_write(16'd2, 16'd1);
        wb_write(16'd0, 16'h000B);
        wait_cycles(4);
        for (int i = 0; i < 2; i++) begin h_arr[i] = 300; l_arr[i] = 100; end
        run_wave(1'b1, 1, 2, 1'b0);
        wait_cycles(6);
        rd_check("t4_period", 16'd4, 16'd400);
        rd_check("t4_high", 16'd6, 16'd300);
        stop_all();

        // randomized continuous runs
        for (int it = 0; it < 4; it++) begin
            div = int'($urandom_range(1, 5));
            wb_write(16'd2, 16'(div));
            wb_write(16'd0, 16'h0003);
            wait_cycles(4);
            for (int i = 0; i < 3; i++) begin
                h_arr[i] = int'($urandom_range(3, 80));
                l_arr[i] = int'($urandom_range(3, 80));
            end
            run_wave(1'b0, div, 3, 1'b0);
            wait_cycles(6);
            rd_check("rnd_period", 16'd4, last_period);
            rd_check("rnd_high", 16'd6, last_high);
            stop_all();
        end

        // abort mid-HIGH, soft reset, then re-arm
        wb_write(16'd2, 16'd1);
        wb_write(16'd0, 16'h0003);
        wait_cycles(4);
        h_arr[0] = 20; l_arr[0] = 40;
        run_wave(1'b0, 1, 1, 1'b0);
        wait_cycles(15);
        wb_write(16'd0, 16'h0000);
        rd_check("t6_status_off", 16'd8, 16'h0001);
        wb_write(16'd0, 16'h0080);
        rd_check("t6_status_srst", 16'd8, 16'd0);
        rd_check("t6_period_kept", 16'd4, 16'd60);
        rd_check("t6_high_kept", 16'd6, 16'd20);
        pwm = 1'b0;
        wait_cycles(6);
        wb_write(16'd0, 16'h0003);
        wait_cycles(4);
        for (int i = 0; i < 2; i++) begin h_arr[i] = 11; l_arr[i] = 9; end
        run_wave(1'b0, 1, 2, 1'b0);
        wait_cycles(6);
        rd_check("t6_period", 16'd4, 16'd20);
        rd_check("t6_high", 16'd6, 16'd11);
        stop_all();

        // stuck-high input saturates the counter
        wb_write(16'd0, 16'h0007);
        wait_cycles(4);
        @(negedge clk);
        pwm = 1'b1;
        wait_cycles(65500);
        rd_check("t5_no_ovf_yet", 16'd8, 16'h0004);
        check16("t5_irq_pre", {15'd0, irq}, 16'd0);
        wait_cycles(45);
        rd_check("t5_status", 16'd8, 16'h0006);
        check16("t5_irq", {15'd0, irq}, 16'd1);
        rd_check("t5_period_kept", 16'd4, 16'd20);
        rd_check("t5_high_kept", 16'd6, 16'd11);
        stop_all();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: %0d measurements outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
